// File: rtl/instr_mem.sv
// Instruction memory with an INIT fill sweep, a one-deep registered fetch response
// and an independent programming write port.
//
// state | meaning
// ------+----------------------------------------------------------
// INIT  | sweeping FILL_WORD into every location, fetches blocked
// RUN   | fetches served with 1-cycle latency, writes accepted
module instr_mem #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_e;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_instr_q;
  logic              rsp_err_q;
  logic              wr_err_q;
  logic              init_done_q;

  logic              fetch_acc;
  logic              fetch_in_rng;
  logic              wr_in_rng;
  logic              wr_ok;
  logic              wr_drop;
  logic [DATA_W-1:0] rsp_instr_d;
  logic              rsp_err_d;

  assign req_ready    = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  assign fetch_acc    = req_valid && req_ready;
  assign fetch_in_rng = {1'b0, req_addr} < DEPTH_L;
  assign wr_in_rng    = {1'b0, wr_addr} < DEPTH_L;
  assign wr_ok        = wr_en && (state_q == RUN) && wr_in_rng;
  assign wr_drop      = wr_en && !wr_ok;

  // Out-of-range fetches never touch the array.
  always_comb begin
    rsp_instr_d = '0;
    rsp_err_d   = 1'b1;
    if (fetch_in_rng) begin
      rsp_instr_d = mem_q[req_addr];
      rsp_err_d   = 1'b0;
    end
  end

  // No reset on the array: only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= FILL_WORD;
      end else if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      wr_err_q <= wr_drop;
      if (state_q == INIT) begin
        if (init_cnt_q == LAST_L) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end else begin
          init_cnt_q <= init_cnt_q + 1'b1;
        end
      end
      if (fetch_acc) begin
        rsp_valid_q <= 1'b1;
        rsp_instr_q <= rsp_instr_d;
        rsp_err_q   <= rsp_err_d;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign wr_err    = wr_err_q;
  assign init_done = init_done_q;

endmodule
